// File: rtl/nk_board_game_core.sv
// N x N, K-in-a-row two-player game core: board, cursor, turn and result state.
// Optional forced turn pass on idle timeout when TURN_TIMEOUT_EN is defined.
module nk_board_game_core #(
  parameter int          N              = 3,
  parameter int          K              = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                         CLOCK_50,
  input  logic                         rst,
  input  logic                         btn_next,
  input  logic                         btn_sel,
  input  logic                         new_game,
  output logic [2*N*N-1:0]             board,
  output logic [$clog2(N*N)-1:0]       cursor,
  output logic                         turn,
  output logic [1:0]                   who,
  output logic                         busy,
  output logic [$clog2(N*N+1)-1:0]     move_count,
  output logic                         timeout_flag
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN);
  localparam int MW = $clog2(NN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t             r_state;
  logic [NN-1:0][1:0] r_cells;
  logic [CW-1:0]      r_cursor;
  logic               r_turn;
  logic [1:0]         r_who;
  logic               r_busy;
  logic [MW-1:0]      r_moves;
  logic [CW-1:0]      r_scell;
  logic [1:0]         r_dir;
  logic               r_hit;
  logic [2:0]         r_nsync;
  logic [2:0]         r_ssync;

  logic               w_next_evt;
  logic               w_sel_evt;
  logic [1:0]         w_mark;
  logic               w_hit;
  logic               w_last;

  assign w_next_evt = r_nsync[1] & ~r_nsync[2];
  assign w_sel_evt  = r_ssync[1] & ~r_ssync[2];
  assign w_mark     = r_turn ? 2'b10 : 2'b01;
  assign w_last     = (r_scell == CW'(NN - 1)) && (r_dir == 2'd3);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_nsync <= '0;
      r_ssync <= '0;
    end else begin
      r_nsync <= {r_nsync[1:0], btn_next};
      r_ssync <= {r_ssync[1:0], btn_sel};
    end
  end

  // Direction order per cell: E, S, SE, SW.
  always_comb begin
    int row;
    int col;
    int dr;
    int dc;
    row   = int'(r_scell) / N;
    col   = int'(r_scell) % N;
    dr    = 1;
    dc    = 0;
    w_hit = 1'b1;
    case (r_dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if ((row + dr * (K - 1) >= N) || (col + dc * (K - 1) < 0) ||
        (col + dc * (K - 1) >= N)) begin
      w_hit = 1'b0;
    end else begin
      for (int unsigned k = 0; k < K; k++) begin
        if (r_cells[CW'((row + dr * int'(k)) * N + col + dc * int'(k))] != w_mark)
          w_hit = 1'b0;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to_flag;
  assign timeout_flag = r_to_flag;
`else
  assign timeout_flag = 1'b0 & TIMEOUT_CYCLES[0];
`endif

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst || new_game) begin
      r_state   <= S_IDLE;
      r_cells   <= '0;
      r_cursor  <= '0;
      r_turn    <= 1'b0;
      r_who     <= 2'b00;
      r_busy    <= 1'b0;
      r_moves   <= '0;
      r_scell   <= '0;
      r_dir     <= '0;
      r_hit     <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
`endif
    end else begin
`ifdef TURN_TIMEOUT_EN
      r_to_flag <= 1'b0;
      if (r_state != S_IDLE) r_to_cnt <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_sel_evt) begin
            if (r_cells[r_cursor] == 2'b00) begin
              r_cells[r_cursor] <= w_mark;
              r_moves           <= r_moves + 1'b1;
              r_scell           <= '0;
              r_dir             <= '0;
              r_hit             <= 1'b0;
              r_busy            <= 1'b1;
              r_state           <= S_CHECK;
            end
          end else if (w_next_evt) begin
            r_cursor <= (r_cursor == CW'(NN - 1)) ? '0 : r_cursor + 1'b1;
          end
`ifdef TURN_TIMEOUT_EN
          if ((w_sel_evt && r_cells[r_cursor] == 2'b00) || (!w_sel_evt && w_next_evt)) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            r_to_cnt  <= '0;
            r_turn    <= ~r_turn;
            r_to_flag <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (w_last) begin
            r_busy <= 1'b0;
            if (r_hit || w_hit) begin
              r_who    <= w_mark;
              r_cursor <= '1;
              r_state  <= S_DONE;
            end else if (r_moves == MW'(NN)) begin
              r_who    <= 2'b11;
              r_cursor <= '1;
              r_state  <= S_DONE;
            end else begin
              r_turn  <= ~r_turn;
              r_state <= S_IDLE;
            end
          end else begin
            r_hit <= r_hit | w_hit;
            r_dir <= r_dir + 1'b1;
            if (r_dir == 2'd3) r_scell <= r_scell + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign board      = r_cells;
  assign cursor     = r_cursor;
  assign turn       = r_turn;
  assign who        = r_who;
  assign busy       = r_busy;
  assign move_count = r_moves;

endmodule

// File: tb/tb_nk_board_game_core.sv
// Self-checking bench for nk_board_game_core (N=3, K=3, TIMEOUT_CYCLES=20).
// Directed scenarios plus random games checked against an array-based game model.
module tb_nk_board_game_core;
  localparam int N  = 3;
  localparam int K  = 3;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst, bn, bs, ng;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  who;
  logic        busy;
  logic [3:0]  move_count;
  logic        timeout_flag;

  int total = 0;
  int bad   = 0;

  int m_cell[NN];
  int m_cur, m_turn, m_who, m_cnt;

  nk_board_game_core #(.N(N), .K(K), .TIMEOUT_CYCLES(20)) dut (
    .CLOCK_50(clk), .rst(rst), .btn_next(bn), .btn_sel(bs), .new_game(ng),
    .board(board), .cursor(cursor), .turn(turn), .who(who), .busy(busy),
    .move_count(move_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NN; i++) m_cell[i] = 0;
    m_cur = 0; m_turn = 0; m_who = 0; m_cnt = 0;
  endtask

  function automatic bit m_win(input int mark);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int k = 0; k < K; k++) begin
            int rr = r + dr[d] * k;
            int cc = c + dc[d] * k;
            if (rr < 0 || rr >= N || cc < 0 || cc >= N) ok = 1'b0;
            else if (m_cell[rr * N + cc] != mark) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [17:0] m_board();
    logic [17:0] b = '0;
    for (int i = 0; i < NN; i++) b[2*i +: 2] = 2'(m_cell[i]);
    return b;
  endfunction

  task automatic m_sel();
    if (m_who == 0 && m_cell[m_cur] == 0) begin
      int mark = m_turn ? 2 : 1;
      m_cell[m_cur] = mark;
      m_cnt++;
      if (m_win(mark)) m_who = mark;
      else if (m_cnt == NN) m_who = 3;
      else m_turn ^= 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".board"}, 32'(board), 32'(m_board()));
    chk({tag, ".who"}, 32'(who), 32'(m_who));
    chk({tag, ".turn"}, 32'(turn), 32'(m_turn));
    chk({tag, ".moves"}, 32'(move_count), 32'(m_cnt));
    chk({tag, ".cursor"}, 32'(cursor), (m_who != 0) ? 32'd15 : 32'(m_cur));
  endtask

  task automatic pulse(input logic n, input logic s, output logic bsy);
    @(negedge clk);
    bn = n; bs = s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bsy = busy;
    bn = 1'b0; bs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_next();
    logic b;
    pulse(1'b1, 1'b0, b);
    if (m_who == 0) m_cur = (m_cur + 1) % NN;
  endtask

  task automatic do_sel(input string tag);
    logic b;
    bit   acc = (m_who == 0 && m_cell[m_cur] == 0);
    pulse(1'b0, 1'b1, b);
    chk({tag, ".busy"}, 32'(b), 32'(acc));
    wait_idle();
    m_sel();
  endtask

  task automatic go_to(input int t);
    while (m_cur != t && m_who == 0) do_next();
  endtask

  task automatic do_new_game();
    @(negedge clk); ng = 1'b1;
    @(negedge clk); ng = 1'b0;
    m_reset();
  endtask

  initial begin
    int seq1[5] = '{0, 4, 1, 5, 2};
    int seq2[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    logic b;
    int   flags;
    rst = 1'b1; bn = 1'b0; bs = 1'b0; ng = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.board", 32'(board), 32'd0);
    chk("rst.cursor", 32'(cursor), 32'd0);
    chk("rst.turn", 32'(turn), 32'd0);
    chk("rst.who", 32'(who), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.moves", 32'(move_count), 32'd0);
    chk("rst.tflag", 32'(timeout_flag), 32'd0);

    // Idle timeout behaviour.
    do_new_game();
    flags = 0;
    repeat (25) begin
      @(negedge clk);
      if (timeout_flag) flags++;
    end
`ifdef TURN_TIMEOUT_EN
    chk("t6.turn", 32'(turn), 32'd1);
    chk("t6.flags", 32'(flags), 32'd1);
`else
    chk("t6.turn", 32'(turn), 32'd0);
    chk("t6.flags", 32'(flags), 32'd0);
`endif

    // X wins on the top row.
    do_new_game();
    foreach (seq1[i]) begin
      go_to(seq1[i]);
      do_sel("t1.sel");
    end
    chk("t1.who", 32'(who), 32'd1);
    chk("t1.row0", 32'(board[5:0]), 32'b010101);
    check_all("t1");
    do_next();
    do_sel("t1.frozen");
    check_all("t1.frozen");

    // Full board, no line.
    do_new_game();
    foreach (seq2[i]) begin
      go_to(seq2[i]);
      do_sel("t2.sel");
    end
    chk("t2.who", 32'(who), 32'd3);
    chk("t2.moves", 32'(move_count), 32'd9);
    chk("t2.cursor", 32'(cursor), 32'd15);

    // Selecting an occupied cell is ignored.
    do_new_game();
    go_to(4);
    do_sel("t3.first");
    do_sel("t3.occ");
    check_all("t3");

    // Cursor wrap and next+sel collision.
    do_new_game();
    repeat (9) do_next();
    chk("t4.wrap", 32'(cursor), 32'd0);
    go_to(2);
    pulse(1'b1, 1'b1, b);
    chk("t4.busy", 32'(b), 32'd1);
    wait_idle();
    m_sel();
    check_all("t4");

    // new_game mid-scan.
    do_new_game();
    pulse(1'b0, 1'b1, b);
    chk("t5.busy_in", 32'(b), 32'd1);
    @(negedge clk);
    ng = 1'b1;
    @(negedge clk);
    ng = 1'b0;
    m_reset();
    chk("t5.board", 32'(board), 32'd0);
    chk("t5.who", 32'(who), 32'd0);
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.turn", 32'(turn), 32'd0);

    // Asynchronous reset mid-scan.
    go_to(3);
    pulse(1'b0, 1'b1, b);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (50) @(negedge clk);
    check_all("rstmid");
    chk("rstmid.busy", 32'(busy), 32'd0);

    // Random games.
    for (int g = 0; g < 5; g++) begin
      do_new_game();
      for (int st = 0; st < 80 && m_who == 0; st++) begin
        if ($urandom_range(0, 9) < 6) do_next();
        else begin
          do_sel("rnd.sel");
          check_all("rnd");
        end
      end
      check_all("rnd.end");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
